// File: rtl/main.sv
//------------------------------------------------------------------------------
// main : BLDC Hall-sensor commutation and 4-bit PWM gate controller.
// The MAIN_DEADTIME_EN macro enables dead-time blanking on every step change.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module main #(
  parameter int PWM_PRESCALE = 1,
  parameter int DEAD_CYCLES  = 4
) (
  input  logic CLK,
  input  logic LOW,
  input  logic H1,
  input  logic H2,
  input  logic H3,
  input  logic D3,
  input  logic D2,
  input  logic D1,
  input  logic D0,
  output logic A_OUT,
  output logic B_OUT,
  output logic C_OUT,
  output logic AA_OUT,
  output logic BB_OUT,
  output logic CC_OUT
);

  localparam int c_pre_w = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
  localparam logic [c_pre_w-1:0] c_pre_max = c_pre_w'(PWM_PRESCALE - 1);

  if (PWM_PRESCALE < 1) begin : g_bad_prescale
    $error("PWM_PRESCALE must be >= 1");
  end
  if (DEAD_CYCLES < 1) begin : g_bad_dead_cycles
    $error("DEAD_CYCLES must be >= 1");
  end

  logic [2:0]         sync1_q;
  logic [2:0]         hall_q;
  logic [c_pre_w-1:0] pre_q;
  logic [3:0]         p_q;
  logic [3:0]         dlat_q;
  logic [5:0]         out_q;   // {A,B,C,AA,BB,CC}
  logic [5:0]         out_d;

  logic [3:0] w_duty;
  logic       w_pwm_step;
  logic       w_wrap;
  logic       w_pwm;
  logic       w_blank;
  logic [5:0] w_step;

  assign w_duty     = {D3, D2, D1, D0};
  assign w_pwm_step = (pre_q == c_pre_max);
  assign w_wrap     = w_pwm_step && (p_q == 4'd15);
  assign w_pwm      = (p_q < dlat_q);

  always_ff @(posedge CLK or posedge LOW) begin
    if (LOW) begin
      sync1_q <= 3'b000;
      hall_q  <= 3'b000;
      pre_q   <= '0;
      p_q     <= 4'd0;
      dlat_q  <= 4'd0;
      out_q   <= 6'b000000;
    end else begin
      sync1_q <= {H3, H2, H1};
      hall_q  <= sync1_q;
      pre_q   <= w_pwm_step ? '0 : pre_q + 1'b1;
      if (w_pwm_step) p_q <= p_q + 4'd1;
      if (w_wrap) dlat_q <= w_duty;
      out_q   <= out_d;
    end
  end

  // High side is chopped, low side of the same pair is held for the whole step.
  always_comb begin
    w_step = 6'b000000;
    case (hall_q)
      3'b001:  w_step = {w_pwm, 1'b0, 1'b0, 3'b010};
      3'b101:  w_step = {w_pwm, 1'b0, 1'b0, 3'b001};
      3'b100:  w_step = {1'b0, w_pwm, 1'b0, 3'b001};
      3'b110:  w_step = {1'b0, w_pwm, 1'b0, 3'b100};
      3'b010:  w_step = {1'b0, 1'b0, w_pwm, 3'b100};
      3'b011:  w_step = {1'b0, 1'b0, w_pwm, 3'b010};
      default: w_step = 6'b000000;
    endcase
  end

`ifdef MAIN_DEADTIME_EN
  localparam int c_dead_w = $clog2(DEAD_CYCLES + 1);
  localparam logic [c_dead_w-1:0] c_dead_load = c_dead_w'(DEAD_CYCLES - 1);

  logic [2:0]          hall_prev_q;
  logic [c_dead_w-1:0] dead_q;
  logic                w_change;

  assign w_change = (hall_q != hall_prev_q);

  // The change cycle itself blanks, then the counter covers the rest of the gap.
  always_ff @(posedge CLK or posedge LOW) begin
    if (LOW) begin
      hall_prev_q <= 3'b000;
      dead_q      <= '0;
    end else begin
      hall_prev_q <= hall_q;
      if (w_change) dead_q <= c_dead_load;
      else if (dead_q != '0) dead_q <= dead_q - 1'b1;
    end
  end

  assign w_blank = w_change || (dead_q != '0);
`else
  assign w_blank = 1'b0;
`endif

  assign out_d = w_blank ? 6'b000000 : w_step;

  assign {A_OUT, B_OUT, C_OUT, AA_OUT, BB_OUT, CC_OUT} = out_q;

endmodule

`default_nettype wire

// File: tb/tb_main.sv
//------------------------------------------------------------------------------
// tb_main : directed vector bench for the BLDC commutation/PWM controller.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_main;

`ifdef MAIN_DEADTIME_EN
  localparam int DT = 4;
`else
  localparam int DT = 0;
`endif

  logic CLK = 1'b0;
  logic LOW = 1'b1;
  logic H1 = 1'b0, H2 = 1'b0, H3 = 1'b0;
  logic D3 = 1'b0, D2 = 1'b0, D1 = 1'b0, D0 = 1'b0;
  logic A_OUT, B_OUT, C_OUT, AA_OUT, BB_OUT, CC_OUT;
  logic [5:0] o;

  assign o = {A_OUT, B_OUT, C_OUT, AA_OUT, BB_OUT, CC_OUT};

  main #(.PWM_PRESCALE(1), .DEAD_CYCLES(4)) dut (
    .CLK   (CLK),
    .LOW   (LOW),
    .H1    (H1),
    .H2    (H2),
    .H3    (H3),
    .D3    (D3),
    .D2    (D2),
    .D1    (D1),
    .D0    (D0),
    .A_OUT (A_OUT),
    .B_OUT (B_OUT),
    .C_OUT (C_OUT),
    .AA_OUT(AA_OUT),
    .BB_OUT(BB_OUT),
    .CC_OUT(CC_OUT)
  );

  always #10 CLK = ~CLK;

  typedef struct {
    logic [2:0] hall;
    logic [3:0] duty;
    logic [2:0] hi;   // expected high-side phase {A,B,C}
    logic [2:0] lo;   // expected low-side pattern {AA,BB,CC}
    int         cnt;  // expected high-side cycles per 16
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  vec_t vt[12];

  function automatic vec_t mk(input logic [2:0] h, input logic [3:0] d,
                              input logic [2:0] hi, input logic [2:0] lo, input int c);
    vec_t v;
    v.hall = h; v.duty = d; v.hi = hi; v.lo = lo; v.cnt = c;
    return v;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_in(input logic [2:0] h, input logic [3:0] d);
    {H3, H2, H1} = h;
    {D3, D2, D1, D0} = d;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    int first, hi_cnt, bad, zeros, cnt1, cnt2, viol, found;
    logic [2:0] e;
    logic prev;

    vt[0]  = mk(3'b001, 4'd4,  3'b100, 3'b010, 4);
    vt[1]  = mk(3'b101, 4'd4,  3'b100, 3'b001, 4);
    vt[2]  = mk(3'b100, 4'd4,  3'b010, 3'b001, 4);
    vt[3]  = mk(3'b110, 4'd4,  3'b010, 3'b100, 4);
    vt[4]  = mk(3'b010, 4'd4,  3'b001, 3'b100, 4);
    vt[5]  = mk(3'b011, 4'd4,  3'b001, 3'b010, 4);
    vt[6]  = mk(3'b001, 4'd4,  3'b100, 3'b010, 4);
    vt[7]  = mk(3'b001, 4'd0,  3'b100, 3'b010, 0);
    vt[8]  = mk(3'b001, 4'd15, 3'b100, 3'b010, 15);
    vt[9]  = mk(3'b000, 4'd4,  3'b000, 3'b000, 0);
    vt[10] = mk(3'b111, 4'd4,  3'b000, 3'b000, 0);
    vt[11] = mk(3'b010, 4'd4,  3'b001, 3'b100, 4);

    // Reset hold and release latency
    set_in(3'b001, 4'd4);
    repeat (3) tick();
    check("reset outputs", {26'd0, o}, 32'd0);
    LOW = 1'b0;
    first = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (o != 6'b0) begin
        first = c;
        break;
      end
    end
    check("release latency", first, 3 + DT);
    check("first step pattern", {26'd0, o}, 32'b000010);

    // Steady-state table
    for (int i = 0; i < 12; i++) begin
      set_in(vt[i].hall, vt[i].duty);
      repeat (40) tick();
      hi_cnt = 0;
      bad = 0;
      for (int k = 0; k < 16; k++) begin
        tick();
        if ((o[5:3] & vt[i].hi) != 3'b0) hi_cnt++;
        if (((o[5:3] & ~vt[i].hi) != 3'b0) || (o[2:0] !== vt[i].lo)) bad++;
      end
      check($sformatf("vec%0d hall=%b duty cycles", i, vt[i].hall), hi_cnt, vt[i].cnt);
      check($sformatf("vec%0d hall=%b bad cycles", i, vt[i].hall), bad, 0);
    end

    // Step change with a second change landing inside the dead gap
    set_in(3'b001, 4'd4);
    repeat (40) tick();
    set_in(3'b101, 4'd4);
    bad = 0;
    zeros = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k <= 2) e = 3'b010;
      else if (k <= 6) e = (DT != 0) ? 3'b000 : 3'b001;
      else if (k <= 6 + DT) e = 3'b000;
      else e = 3'b100;
      if (o == 6'b0) zeros++;
      if (e == 3'b000) begin
        if (o !== 6'b0) bad++;
      end else if (o[2:0] !== e) begin
        bad++;
      end
      if (k == 4) set_in(3'b110, 4'd4);
    end
    check("gap seq bad cycles", bad, 0);
    check("gap seq blank cycles", zeros, 2 * DT);

    // Duty change at P=2: current period keeps old duty
    set_in(3'b001, 4'd4);
    repeat (40) tick();
    found = 0;
    prev = A_OUT;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (!prev && A_OUT) begin
        found = 1;
        break;
      end
      prev = A_OUT;
    end
    check("pwm rise seen", found, 1);
    cnt1 = 1;
    for (int k = 2; k <= 16; k++) begin
      tick();
      cnt1 += int'(A_OUT);
      if (k == 2) set_in(3'b001, 4'd12);
    end
    cnt2 = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      cnt2 += int'(A_OUT);
    end
    check("duty change old period", cnt1, 4);
    check("duty change new period", cnt2, 12);

    // Asynchronous reset mid-step
    tick();
    #5 LOW = 1'b1;
    #1 check("async reset", {26'd0, o}, 32'd0);
    tick();
    LOW = 1'b0;

    // Random hall/duty/reset traffic: never both sides of a phase on
    viol = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 7) == 0) {H3, H2, H1} = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 31) == 0) {D3, D2, D1, D0} = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) LOW = 1'b1;
      else if (LOW && $urandom_range(0, 2) == 0) LOW = 1'b0;
      tick();
      if ((A_OUT & AA_OUT) | (B_OUT & BB_OUT) | (C_OUT & CC_OUT)) viol++;
    end
    check("shoot-through cycles", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
